// File: rtl/prod_accum.sv
// Batch accumulator for unsigned multiplier products: IDLE -> ACCUM -> DONE handshake.
// Define PROD_ACCUM_SAT_EN to clamp the accumulator at 2^AW-1 instead of wrapping.
module prod_accum #(
  parameter int PW = 15,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [3:0]    len,
  input  logic [PW-1:0] prod,
  input  logic          prod_valid,
  output logic          prod_ready,
  output logic [AW-1:0] sum,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic          overflow,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [AW-1:0] acc_r;
  logic [4:0]    cnt_r;
  logic [4:0]    len_r;
  logic          ovf_r;
  logic [AW-1:0] sum_r;
  logic          overflow_r;
  logic          xfer_s;
  logic          last_s;
  logic [AW:0]   add_s;

  // One accumulation step at AW+1 bits; bit AW is the carry that flags overflow.
  function automatic logic [AW:0] accum_step(input logic [AW-1:0] a, input logic [PW-1:0] p);
    logic [AW:0] wide;
    wide = {1'b0, a} + {{(AW + 1 - PW){1'b0}}, p};
`ifdef PROD_ACCUM_SAT_EN
    // Once clamped, any further nonzero product carries again, so the value stays pinned.
    if (wide[AW]) begin
      wide = {1'b1, {AW{1'b1}}};
    end else begin
      wide = wide;
    end
`endif
    return wide;
  endfunction

  assign xfer_s = prod_valid && (state_r == ACCUM);
  assign last_s = ((cnt_r + 5'd1) == len_r);
  assign add_s  = accum_step(acc_r, prod);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = ACCUM;
        else       state_s = IDLE;
      end
      ACCUM: begin
        if (xfer_s && last_s) state_s = DONE;
        else                  state_s = ACCUM;
      end
      DONE: begin
        if (sum_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    busy       = 1'b0;
    case (state_r)
      IDLE: begin
        prod_ready = 1'b0;
        sum_valid  = 1'b0;
        busy       = 1'b0;
      end
      ACCUM: begin
        prod_ready = 1'b1;
        sum_valid  = 1'b0;
        busy       = 1'b1;
      end
      DONE: begin
        prod_ready = 1'b0;
        sum_valid  = 1'b1;
        busy       = 1'b1;
      end
      default: begin
        prod_ready = 1'b0;
        sum_valid  = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

  // Datapath: the result register loads only on the final transfer so it holds across IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_r      <= {AW{1'b0}};
      cnt_r      <= 5'd0;
      len_r      <= 5'd0;
      ovf_r      <= 1'b0;
      sum_r      <= {AW{1'b0}};
      overflow_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      acc_r <= {AW{1'b0}};
      cnt_r <= 5'd0;
      len_r <= {(len == 4'd0), len};
      ovf_r <= 1'b0;
    end else if (xfer_s) begin
      acc_r <= add_s[AW-1:0];
      cnt_r <= cnt_r + 5'd1;
      ovf_r <= ovf_r | add_s[AW];
      if (last_s) begin
        sum_r      <= add_s[AW-1:0];
        overflow_r <= ovf_r | add_s[AW];
      end else begin
        sum_r      <= sum_r;
        overflow_r <= overflow_r;
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  assign sum      = sum_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_prod_accum.sv
// Directed self-checking bench for prod_accum (default PW=15, AW=18).
module tb_prod_accum;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  len;
  logic [14:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic [17:0] sum;
  logic        sum_valid;
  logic        sum_ready;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  prod_accum dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .len        (len),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .sum        (sum),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] sat_exp;
`ifdef PROD_ACCUM_SAT_EN
    sat_exp = 32'h3FFFF;
`else
    sat_exp = 32'h3FFF0;
`endif
    reset_n = 1'b0; start = 1'b0; len = 4'd0; prod = 15'd0;
    prod_valid = 1'b0; sum_ready = 1'b0;
    step(); step();
    chk("rst_prod_ready", 32'(prod_ready), 32'd0);
    chk("rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // prod_valid in IDLE is ignored
    reset_n = 1'b1; prod_valid = 1'b1; prod = 15'h1234;
    step();
    chk("idle_prod_ready", 32'(prod_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sum", 32'(sum), 32'd0);

    // len=3 back-to-back
    prod_valid = 1'b0; start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    chk("b1_prod_ready", 32'(prod_ready), 32'd1);
    chk("b1_busy", 32'(busy), 32'd1);
    prod_valid = 1'b1; prod = 15'h0005; step();
    prod = 15'h0010; step();
    chk("b1_not_yet_valid", 32'(sum_valid), 32'd0);
    prod = 15'h7FFF; step();
    prod_valid = 1'b0;
    chk("b1_sum_valid", 32'(sum_valid), 32'd1);
    chk("b1_sum", 32'(sum), 32'h08014);
    chk("b1_overflow", 32'(overflow), 32'd0);
    chk("b1_done_ready", 32'(prod_ready), 32'd0);
    sum_ready = 1'b1; step();
    sum_ready = 1'b0;
    chk("b1_idle_valid", 32'(sum_valid), 32'd0);
    chk("b1_idle_busy", 32'(busy), 32'd0);
    chk("b1_idle_sum_hold", 32'(sum), 32'h08014);

    // len=2 with gapped prod_valid
    start = 1'b1; len = 4'd2; step();
    start = 1'b0;
    prod_valid = 1'b1; prod = 15'h0100; step();
    prod_valid = 1'b0; prod = 15'h7777;
    chk("b2_sum_held_mid", 32'(sum), 32'h08014);
    step(); step();
    chk("b2_still_accum", 32'(prod_ready), 32'd1);
    prod_valid = 1'b1; prod = 15'h0023; step();
    chk("b2_sum_valid", 32'(sum_valid), 32'd1);
    chk("b2_sum", 32'(sum), 32'h00123);
    prod = 15'h7FFF; step();
    prod_valid = 1'b0;
    chk("b2_no_extra", 32'(sum), 32'h00123);

    // DONE held 5 cycles, start pulsed and ignored
    for (int i = 0; i < 5; i++) begin
      start = (i == 2) ? 1'b1 : 1'b0;
      len = 4'd1;
      step();
      chk("hold_sum_valid", 32'(sum_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'h00123);
    end
    start = 1'b1; sum_ready = 1'b1; step();
    start = 1'b0; sum_ready = 1'b0;
    chk("both_to_idle_busy", 32'(busy), 32'd0);
    chk("both_to_idle_ready", 32'(prod_ready), 32'd0);
    step();
    chk("start_not_queued", 32'(busy), 32'd0);

    // len=0 -> 16 transfers of 0x7FFF
    start = 1'b1; len = 4'd0; step();
    start = 1'b0;
    prod_valid = 1'b1; prod = 15'h7FFF;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("b16_not_done", 32'(sum_valid), 32'd0);
    end
    step();
    chk("b16_sum_valid", 32'(sum_valid), 32'd1);
    chk("b16_overflow", 32'(overflow), 32'd1);
    chk("b16_sum", 32'(sum), sat_exp);
    step();
    prod_valid = 1'b0;
    chk("b16_hold", 32'(sum), sat_exp);
    sum_ready = 1'b1; step();
    sum_ready = 1'b0;
    chk("b16_idle", 32'(sum_valid), 32'd0);

    // reset mid-batch after 2 of 4 transfers
    start = 1'b1; len = 4'd4; step();
    start = 1'b0;
    prod_valid = 1'b1; prod = 15'h0001; step();
    prod = 15'h0002; step();
    reset_n = 1'b0; step();
    reset_n = 1'b1; prod_valid = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(prod_ready), 32'd0);
    chk("mid_rst_valid", 32'(sum_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);

    // fresh batch after reset starts from zero
    start = 1'b1; len = 4'd1; step();
    start = 1'b0;
    prod_valid = 1'b1; prod = 15'h0042; step();
    prod_valid = 1'b0;
    chk("post_rst_sum", 32'(sum), 32'h00042);
    chk("post_rst_valid", 32'(sum_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter PW, default 15, product width (matches multiplier product output).
REQ-002 Parameter AW, default 18, accumulator and sum width; AW SHALL be >= PW.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 start  input  1  begin a batch; honoured only in IDLE.
REQ-006 len  input  4  products per batch, sampled with start; 0 means 16.
REQ-007 prod  input  PW  unsigned product from upstream multiplier.
REQ-008 prod_valid  input  1  prod is valid this cycle.
REQ-009 prod_ready  output  1  block accepts prod this cycle.
REQ-010 sum  output  AW  accumulated batch result.
REQ-011 sum_valid  output  1  sum is valid and held.
REQ-012 sum_ready  input  1  downstream consumes sum.
REQ-013 overflow  output  1  batch total exceeded 2^AW-1; valid with sum_valid.
REQ-014 busy  output  1  high in ACCUM or DONE.

Function
REQ-015 FSM states IDLE, ACCUM, DONE; exactly one active at any time.
REQ-016 IDLE: start=1 -> ACCUM next cycle; latch len (0 -> 16), clear accumulator, count and overflow.
REQ-017 IDLE: start=0 -> stay IDLE; prod_valid ignored.
REQ-018 prod_ready SHALL equal 1 exactly when state is ACCUM (combinational from state only, not from prod_valid).
REQ-019 Transfer occurs on a cycle with prod_valid=1 and prod_ready=1; only transfers update accumulator and count.
REQ-020 Each transfer: accumulator <= accumulator + zero-extended prod, computed at AW+1 bits; carry out sets overflow (sticky for the batch).
REQ-021 When the transfer count reaches the latched length, state -> DONE on the same edge; sum_valid asserts the cycle after the last transfer (latency 1).
REQ-022 ACCUM with prod_valid=0: hold all state; no timeout.
REQ-023 DONE: sum, overflow, sum_valid=1 held stable until sum_ready=1; the edge with sum_ready=1 -> IDLE, sum_valid deasserts next cycle.
REQ-024 start while in ACCUM or DONE is ignored and not queued.
REQ-025 start and sum_ready both high in DONE: go to IDLE only; the new batch requires start in IDLE.
REQ-026 sum SHALL hold its last value in IDLE; changes only via accumulation or reset.

Reset
REQ-027 reset_n=0 at a rising edge: state IDLE, accumulator 0, count 0, overflow 0, sum 0, sum_valid 0, prod_ready 0, busy 0.
REQ-028 Reset takes priority over all other inputs, including mid-batch and in DONE; the partial batch is discarded.

Configuration
REQ-029 Macro PROD_ACCUM_SAT_EN: when defined, an accumulation whose AW+1-bit result exceeds 2^AW-1 SHALL clamp the accumulator to 2^AW-1 and hold it there for the rest of the batch; overflow still sets.
REQ-030 Without PROD_ACCUM_SAT_EN, the accumulator wraps modulo 2^AW; overflow still sets.

Verification
REQ-031 Reset mid-ACCUM after 2 of 4 transfers -> next cycle IDLE, sum=0, sum_valid=0, prod_ready=0.
REQ-032 start, len=3, prods 0x0005, 0x0010, 0x7FFF back-to-back -> sum=0x08014, overflow=0, sum_valid 1 cycle after the third transfer.
REQ-033 len=0 with 16 prods of 0x7FFF (AW=18) -> 16 transfers accepted, overflow=1; sum=0x3FFFF with PROD_ACCUM_SAT_EN, 0x3FFF0 without.
REQ-034 len=2 with prod_valid gapped (1,0,0,1) -> exactly 2 transfers, sum equals their total, no extra transfer.
REQ-035 DONE with sum_ready=0 for 5 cycles, start pulsed -> sum and sum_valid stable; start ignored; sum_ready=1 -> IDLE.
REQ-036 prod_valid=1 in IDLE with prod=0x1234 -> prod_ready=0, accumulator unchanged.
